// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS pipe: issues loads/stores on a req/ack data bus,
// stalls the front of the pipe while an access is outstanding, and holds the MEM/WB register.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] npc_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] data2_mem,
  input  logic [4:0]  num_write_mem,
  input  logic [1:0]  s_data_write_mem,
  input  logic        reg_write_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] npc_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] mem_data_wb,
  output logic [4:0]  num_write_wb,
  output logic [1:0]  s_data_write_wb,
  output logic        reg_write_wb,
  output logic        bus_error
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_op, in_wait, timeout, retire, capture, load_hit;

  assign mem_op   = mem_read_mem | mem_write_mem;
  assign in_wait  = (state_q == WAIT);
  assign timeout  = in_wait & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) & ~dmem_ack;
  assign retire   = in_wait & (dmem_ack | timeout);
  assign capture  = (~in_wait & ~mem_op) | retire;
  // A simultaneous read+write is a store, so it never returns load data.
  assign load_hit = in_wait & dmem_ack & mem_read_mem & ~mem_write_mem;

  assign dmem_req   = in_wait;
  assign dmem_we    = mem_write_mem;
  assign dmem_addr  = {alu_result_mem[31:2], 2'b00};
  assign dmem_wdata = data2_mem;
  // Reset forces the stall low so upstream registers can be cleared alongside us.
  assign stall_mem  = ~reset & ((~in_wait & mem_op) | (in_wait & ~dmem_ack & ~timeout));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (retire) state_d = IDLE;
        else        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bus_error       <= 1'b0;
      npc_wb          <= '0;
      alu_result_wb   <= '0;
      mem_data_wb     <= '0;
      num_write_wb    <= '0;
      s_data_write_wb <= '0;
      reg_write_wb    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout) bus_error <= 1'b1;
      if (capture) begin
        npc_wb          <= npc_mem;
        alu_result_wb   <= alu_result_mem;
        mem_data_wb     <= load_hit ? dmem_rdata : 32'h0;
        num_write_wb    <= num_write_mem;
        s_data_write_wb <= s_data_write_mem;
        reg_write_wb    <= reg_write_mem;
      end else begin
        // Bubble: only the write enable drops, the payload holds its last value.
        reg_write_wb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU pass-through, loads/stores with
// varied ack latency, timeout with sticky bus_error, and reset during an access.
module tb_mem_wb_stage;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] npc_mem, alu_result_mem, data2_mem;
  logic [4:0]  num_write_mem;
  logic [1:0]  s_data_write_mem;
  logic        reg_write_mem, mem_write_mem, mem_read_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic [31:0] npc_wb, alu_result_wb, mem_data_wb;
  logic [4:0]  num_write_wb;
  logic [1:0]  s_data_write_wb;
  logic        reg_write_wb, bus_error;

  int tests = 0;
  int fails = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .npc_mem(npc_mem), .alu_result_mem(alu_result_mem), .data2_mem(data2_mem),
    .num_write_mem(num_write_mem), .s_data_write_mem(s_data_write_mem),
    .reg_write_mem(reg_write_mem), .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .npc_wb(npc_wb), .alu_result_wb(alu_result_wb), .mem_data_wb(mem_data_wb),
    .num_write_wb(num_write_wb), .s_data_write_wb(s_data_write_wb),
    .reg_write_wb(reg_write_wb), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    npc_mem = 32'h0; alu_result_mem = 32'h0; data2_mem = 32'h0;
    num_write_mem = 5'd0; s_data_write_mem = 2'd0;
    reg_write_mem = 1'b0; mem_write_mem = 1'b0; mem_read_mem = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      npc_mem = $urandom; alu_result_mem = $urandom; data2_mem = $urandom;
      num_write_mem = 5'($urandom); s_data_write_mem = 2'($urandom);
      reg_write_mem = 1'($urandom); mem_write_mem = 1'($urandom); mem_read_mem = 1'($urandom);
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      tick();
    end
    tests++;
    if ({npc_wb, alu_result_wb, mem_data_wb, num_write_wb, s_data_write_wb, reg_write_wb} !== '0) begin
      fails++; $display("FAIL reset_wb: got npc=%h alu=%h mem=%h num=%0d s=%0d rw=%b, want all 0",
                        npc_wb, alu_result_wb, mem_data_wb, num_write_wb, s_data_write_wb, reg_write_wb);
    end
    tests++;
    if ({dmem_req, stall_mem, bus_error} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got req=%b stall=%b err=%b, want 0 0 0", dmem_req, stall_mem, bus_error);
    end
    idle_inputs();
    reset = 1'b0;
    #1;
    tests++;
    if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL reset_release: got req=%b stall=%b, want 0 0", dmem_req, stall_mem);
    end
  endtask

  task automatic test_alu_op();
    npc_mem = 32'h0000_0044; alu_result_mem = 32'h0000_0010; num_write_mem = 5'd5;
    s_data_write_mem = 2'd2; reg_write_mem = 1'b1;
    #1;
    tests++;
    if (stall_mem !== 1'b0) begin
      fails++; $display("FAIL alu_stall: got %b, want 0", stall_mem);
    end
    tick();
    tests++;
    if (alu_result_wb !== 32'h10 || num_write_wb !== 5'd5 || reg_write_wb !== 1'b1 ||
        npc_wb !== 32'h44 || s_data_write_wb !== 2'd2 || mem_data_wb !== 32'h0) begin
      fails++; $display("FAIL alu_wb: got alu=%h num=%0d rw=%b npc=%h s=%0d mem=%h, want 10 5 1 44 2 0",
                        alu_result_wb, num_write_wb, reg_write_wb, npc_wb, s_data_write_wb, mem_data_wb);
    end
    tests++;
    if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL alu_after: got stall=%b req=%b, want 0 0", stall_mem, dmem_req);
    end
  endtask

  task automatic test_load();
    int stalls = 0;
    int bad = 0;
    npc_mem = 32'h0000_0048; alu_result_mem = 32'h0000_0103; num_write_mem = 5'd7;
    s_data_write_mem = 2'd1; reg_write_mem = 1'b1; mem_read_mem = 1'b1;
    #1;
    if (stall_mem) stalls++;
    if (dmem_req !== 1'b0) bad++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall_mem) stalls++;
      if (dmem_req !== 1'b1 || reg_write_wb !== 1'b0) bad++;
    end
    tests++;
    if (dmem_addr !== 32'h0000_0100 || dmem_we !== 1'b0) begin
      fails++; $display("FAIL load_bus: got addr=%h we=%b, want 00000100 0", dmem_addr, dmem_we);
    end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    #1;
    if (stall_mem) stalls++;
    if (dmem_req !== 1'b1 || reg_write_wb !== 1'b0) bad++;
    tests++;
    if (stalls != 4 || bad != 0) begin
      fails++; $display("FAIL load_stall: got %0d stall cycles, %0d bad req/bubble cycles, want 4 and 0", stalls, bad);
    end
    tick();
    idle_inputs();
    tests++;
    if (mem_data_wb !== 32'hCAFE_BABE || reg_write_wb !== 1'b1 || num_write_wb !== 5'd7 ||
        alu_result_wb !== 32'h103 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL load_wb: got mem=%h rw=%b num=%0d alu=%h req=%b, want cafebabe 1 7 103 0",
                        mem_data_wb, reg_write_wb, num_write_wb, alu_result_wb, dmem_req);
    end
  endtask

  task automatic test_store();
    alu_result_mem = 32'h0000_0200; data2_mem = 32'h1234_5678; mem_write_mem = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (stall_mem !== 1'b1 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL store_issue: got stall=%b req=%b, want 1 0", stall_mem, dmem_req);
    end
    tick();
    dmem_ack = 1'b1;
    #1;
    tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h1234_5678 || stall_mem !== 1'b0) begin
      fails++; $display("FAIL store_req: got req=%b we=%b wdata=%h stall=%b, want 1 1 12345678 0",
                        dmem_req, dmem_we, dmem_wdata, stall_mem);
    end
    tick();
    idle_inputs();
    tests++;
    if (mem_data_wb !== 32'h0 || alu_result_wb !== 32'h200 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL store_wb: got mem=%h alu=%h req=%b, want 0 200 0", mem_data_wb, alu_result_wb, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    // Read+write together behaves as a store; a second load follows with no zero-gap request.
    alu_result_mem = 32'h0000_0301; mem_read_mem = 1'b1; mem_write_mem = 1'b1;
    reg_write_mem = 1'b1; num_write_mem = 5'd9;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    tests++;
    if (dmem_we !== 1'b1 || dmem_addr !== 32'h300) begin
      fails++; $display("FAIL rw_bus: got we=%b addr=%h, want 1 00000300", dmem_we, dmem_addr);
    end
    tick();
    dmem_ack = 1'b0; mem_write_mem = 1'b0; alu_result_mem = 32'h0000_0400; num_write_mem = 5'd10;
    #1;
    tests++;
    if (mem_data_wb !== 32'h0 || reg_write_wb !== 1'b1 || dmem_req !== 1'b0 || stall_mem !== 1'b1) begin
      fails++; $display("FAIL b2b_gap: got mem=%h rw=%b req=%b stall=%b, want 0 1 0 1",
                        mem_data_wb, reg_write_wb, dmem_req, stall_mem);
    end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    tests++;
    if (mem_data_wb !== 32'h0BAD_F00D || num_write_wb !== 5'd10 || reg_write_wb !== 1'b1) begin
      fails++; $display("FAIL b2b_load: got mem=%h num=%0d rw=%b, want 0badf00d 10 1",
                        mem_data_wb, num_write_wb, reg_write_wb);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    alu_result_mem = 32'h0000_0500; mem_read_mem = 1'b1; reg_write_mem = 1'b1;
    num_write_mem = 5'd3; dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < TO; i++) begin
      tick();
      if (dmem_req !== 1'b1 || bus_error !== 1'b0) bad++;
      if (stall_mem !== ((i < TO - 1) ? 1'b1 : 1'b0)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL timeout_wait: got %0d bad cycles over %0d WAIT cycles, want 0", bad, TO);
    end
    tick();
    idle_inputs();
    tests++;
    if (bus_error !== 1'b1 || mem_data_wb !== 32'h0 || reg_write_wb !== 1'b1 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL timeout_retire: got err=%b mem=%h rw=%b req=%b, want 1 0 1 0",
                        bus_error, mem_data_wb, reg_write_wb, dmem_req);
    end
    alu_result_mem = 32'h0000_0020; reg_write_mem = 1'b1;
    tick(); tick();
    tests++;
    if (bus_error !== 1'b1 || alu_result_wb !== 32'h20) begin
      fails++; $display("FAIL bus_error_sticky: got err=%b alu=%h, want 1 00000020", bus_error, alu_result_wb);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    alu_result_mem = 32'h0000_0600; mem_read_mem = 1'b1; reg_write_mem = 1'b1; num_write_mem = 5'd4;
    tick();
    tick();
    reset = 1'b1;
    #1;
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++; $display("FAIL rst_wait_pre: got req=%b, want 1", dmem_req);
    end
    tick();
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    #1;
    tests++;
    if (dmem_req !== 1'b0 || reg_write_wb !== 1'b0 || bus_error !== 1'b0) begin
      fails++; $display("FAIL rst_wait_idle: got req=%b rw=%b err=%b, want 0 0 0", dmem_req, reg_write_wb, bus_error);
    end
    tick();
    dmem_ack = 1'b0;
    tests++;
    if (reg_write_wb !== 1'b0 || mem_data_wb !== 32'h0) begin
      fails++; $display("FAIL rst_late_ack: got rw=%b mem=%h, want 0 0", reg_write_wb, mem_data_wb);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
